// File: rtl/fsm_chk_pkg.sv
// ============================================================================
//  Module   : fsm_chk_pkg
//  Purpose  : Shared types and vector-word layout for the FSM vector checker.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fsm_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Table word layout: {x[2:0], exp_y[2:0], exp_z[2:0]}
   localparam int VEC_W = 9;
   localparam int EXP_W = 6;
   localparam int X_MSB = 8;
   localparam int X_LSB = 6;
   localparam int Y_MSB = 5;
   localparam int Y_LSB = 3;
   localparam int Z_MSB = 2;
   localparam int Z_LSB = 0;

   localparam logic [7:0] ERR_MAX = 8'd255;

   typedef logic [VEC_W-1:0] vec_t;

endpackage

`default_nettype wire

// File: rtl/fsm_chk_pipe.sv
// ============================================================================
//  Module   : fsm_chk_pipe
//  Purpose  : LAT-deep delay line carrying {valid, idx, exp_y, exp_z}.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fsm_chk_pipe
   import fsm_chk_pkg::*;
#(
   parameter int LAT = 1,
   parameter int AW  = 4
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             flush_i,
   input  logic             valid_i,
   input  logic [AW-1:0]    idx_i,
   input  logic [EXP_W-1:0] exp_i,
   output logic             valid_o,
   output logic [AW-1:0]    idx_o,
   output logic [EXP_W-1:0] exp_o
);

   logic [LAT-1:0]   valid_q;
   logic [AW-1:0]    idx_q [LAT];
   logic [EXP_W-1:0] exp_q [LAT];

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         valid_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            idx_q[i] <= '0;
            exp_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= valid_i & ~flush_i;
         idx_q[0]   <= idx_i;
         exp_q[0]   <= exp_i;
         for (int i = 1; i < LAT; i++) begin
            valid_q[i] <= valid_q[i-1] & ~flush_i;
            idx_q[i]   <= idx_q[i-1];
            exp_q[i]   <= exp_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[LAT-1];
   assign idx_o   = idx_q[LAT-1];
   assign exp_o   = exp_q[LAT-1];

endmodule

`default_nettype wire

// File: rtl/fsm_vector_checker.sv
// ============================================================================
//  Module   : fsm_vector_checker
//  Purpose  : Plays stored x vectors into an FSM and checks its y/z replies.
//             Optional macro STOP_ON_FAIL_EN ends a run at the first mismatch.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fsm_vector_checker
   import fsm_chk_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int CHK_LAT = 1
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [VEC_W-1:0] wr_data,
   input  logic [AW:0]      num_vec,
   input  logic             start,
   output logic             x1,
   output logic             x2,
   output logic             x3,
   input  logic [2:0]       y,
   input  logic [2:0]       z,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [7:0]       err_cnt,
   output logic [AW-1:0]    first_fail
);

   localparam logic [AW:0] DEPTH_W    = (AW+1)'(DEPTH);
   localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
   localparam logic [1:0]  DRAIN_LAST = 2'(CHK_LAT - 1);

   state_t            state_q, state_d;
   logic [AW:0]       ptr_q, ptr_d;
   logic [AW:0]       n_q, n_d;
   logic [1:0]        drain_q, drain_d;
   logic [2:0]        x_q, x_d;
   logic [7:0]        err_q, err_d;
   logic [AW-1:0]     ff_q, ff_d;

   vec_t              tbl_q [DEPTH];
   vec_t              rd_vec;
   logic [AW-1:0]     rd_idx;
   logic              idle_like;

   logic              pipe_vld_in, pipe_flush;
   logic              pipe_vld;
   logic [AW-1:0]     pipe_idx;
   logic [EXP_W-1:0]  pipe_exp;
   logic              mismatch;

   assign idle_like = (state_q == IDLE) || (state_q == DONE);
   assign rd_idx    = ptr_q[AW-1:0];
   assign rd_vec    = tbl_q[rd_idx];
   assign mismatch  = pipe_vld && ({y, z} != pipe_exp);

   // Table has no reset so stored vectors survive an nreset pulse.
   always_ff @(posedge clk) begin
      if (wr_en && idle_like) begin
         tbl_q[wr_addr] <= wr_data;
      end
   end

   fsm_chk_pipe #(
      .LAT (CHK_LAT),
      .AW  (AW)
   ) u_pipe (
      .clk     (clk),
      .nreset  (nreset),
      .flush_i (pipe_flush),
      .valid_i (pipe_vld_in),
      .idx_i   (rd_idx),
      .exp_i   (rd_vec[Y_MSB:Z_LSB]),
      .valid_o (pipe_vld),
      .idx_o   (pipe_idx),
      .exp_o   (pipe_exp)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      n_d         = n_q;
      drain_d     = drain_q;
      x_d         = 3'b000;
      err_d       = err_q;
      ff_d        = ff_q;
      pipe_vld_in = 1'b0;
      pipe_flush  = 1'b0;

      if (mismatch) begin
         if (err_q != ERR_MAX) err_d = err_q + 8'd1;
         if (err_q == 8'd0)    ff_d  = pipe_idx;
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               n_d     = (num_vec > DEPTH_W) ? DEPTH_W : num_vec;
               ptr_d   = '0;
               drain_d = '0;
               err_d   = '0;
               ff_d    = '0;
               state_d = (num_vec == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            x_d         = rd_vec[X_MSB:X_LSB];
            pipe_vld_in = 1'b1;
            ptr_d       = ptr_q + PTR_ONE;
            if (ptr_q == n_q - PTR_ONE) begin
               state_d = DRAIN;
               drain_d = '0;
            end
         end
         DRAIN: begin
            if (drain_q == DRAIN_LAST) state_d = DONE;
            else                       drain_d = drain_q + 2'd1;
         end
         default: state_d = IDLE;
      endcase

`ifdef STOP_ON_FAIL_EN
      // Abort: stop stimulus and drop any checks still in flight.
      if (mismatch) begin
         state_d     = DONE;
         x_d         = 3'b000;
         pipe_vld_in = 1'b0;
         pipe_flush  = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         n_q     <= '0;
         drain_q <= '0;
         x_q     <= 3'b000;
         err_q   <= '0;
         ff_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         n_q     <= n_d;
         drain_q <= drain_d;
         x_q     <= x_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
      end
   end

   assign {x1, x2, x3} = x_q;
   assign busy         = (state_q == RUN) || (state_q == DRAIN);
   assign done         = (state_q == DONE);
   assign pass         = (state_q == DONE) && (err_q == 8'd0);
   assign err_cnt      = err_q;
   assign first_fail   = ff_q;

endmodule

`default_nettype wire

// File: tb/tb_fsm_vector_checker.sv
// ============================================================================
//  Module   : tb_fsm_vector_checker
//  Purpose  : Directed bench for fsm_vector_checker with a combinational FSM
//             stand-in (y = ~x, z = {x1&x2, x2|x3, ^x}); honours STOP_ON_FAIL_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fsm_vector_checker;

   logic       clk = 1'b0;
   logic       nreset;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [8:0] wr_data;
   logic [4:0] num_vec;
   logic       start;
   logic       x1, x2, x3;
   logic [2:0] y, z;
   logic       busy, done, pass;
   logic [7:0] err_cnt;
   logic [3:0] first_fail;
   logic       tie_off;
   logic [2:0] xv;

   logic       b_wr_en;
   logic [8:0] b_wr_addr;
   logic [8:0] b_wr_data;
   logic [9:0] b_num_vec;
   logic       b_start;
   logic       b_x1, b_x2, b_x3;
   logic       b_busy, b_done, b_pass;
   logic [7:0] b_err;
   logic [8:0] b_ff;

   logic [8:0] gold [10];
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc;

   always #5 clk = ~clk;

   assign xv = {x1, x2, x3};
   assign y  = tie_off ? 3'b000 : ~xv;
   assign z  = tie_off ? 3'b000 : {xv[2] & xv[1], xv[1] | xv[0], ^xv};

   fsm_vector_checker #(.DEPTH(16), .AW(4), .CHK_LAT(1)) u_dut (
      .clk        (clk),
      .nreset     (nreset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .num_vec    (num_vec),
      .start      (start),
      .x1         (x1),
      .x2         (x2),
      .x3         (x3),
      .y          (y),
      .z          (z),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_cnt    (err_cnt),
      .first_fail (first_fail)
   );

   // Deep instance, used to push the error counter into saturation.
   fsm_vector_checker #(.DEPTH(512), .AW(9), .CHK_LAT(2)) u_big (
      .clk        (clk),
      .nreset     (nreset),
      .wr_en      (b_wr_en),
      .wr_addr    (b_wr_addr),
      .wr_data    (b_wr_data),
      .num_vec    (b_num_vec),
      .start      (b_start),
      .x1         (b_x1),
      .x2         (b_x2),
      .x3         (b_x3),
      .y          (3'b000),
      .z          (3'b000),
      .busy       (b_busy),
      .done       (b_done),
      .pass       (b_pass),
      .err_cnt    (b_err),
      .first_fail (b_ff)
   );

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_vec++;
      if (obs != exp_v) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic wr(input int a, input logic [8:0] d);
      wr_en   = 1'b1;
      wr_addr = a[3:0];
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // Cycle count = number of negedges after the start cycle until done is seen.
   task automatic run(input int nv, input bit inject, output int c);
      start   = 1'b1;
      num_vec = nv[4:0];
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      c     = 1;
      while (!done && c < 200) begin
         if (inject && c == 3) begin
            wr_en   = 1'b1;
            wr_addr = 4'd4;
            wr_data = 9'b011_000_000;
            start   = 1'b1;
            num_vec = 5'd0;
         end
         @(negedge clk);
         c++;
         wr_en = 1'b0;
         start = 1'b0;
      end
      chk("run_done", int'(done), 1);
   endtask

   initial begin
      gold[0] = 9'b100_011_001;
      gold[1] = 9'b010_101_011;
      gold[2] = 9'b000_111_000;
      gold[3] = 9'b000_111_000;
      gold[4] = 9'b011_100_010;
      gold[5] = 9'b011_100_010;
      gold[6] = 9'b001_110_011;
      gold[7] = 9'b000_111_000;
      gold[8] = 9'b000_111_000;
      gold[9] = 9'b000_111_000;

      nreset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; num_vec = '0;
      start = 1'b0; tie_off = 1'b0;
      b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_num_vec = '0; b_start = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pass", int'(pass), 0);
      chk("rst_err",  int'(err_cnt), 0);
      chk("rst_ff",   int'(first_fail), 0);
      chk("rst_x",    int'(xv), 0);
      nreset = 1'b1;
      @(negedge clk);

      // Golden run of ten vectors
      for (int i = 0; i < 10; i++) wr(i, gold[i]);
      run(10, 1'b0, cyc);
      chk("t1_cycles", cyc, 12);
      chk("t1_pass", int'(pass), 1);
      chk("t1_err", int'(err_cnt), 0);
      chk("t1_x_idle", int'(xv), 0);

      // Empty run
      run(0, 1'b0, cyc);
      chk("t3_cycles", cyc, 1);
      chk("t3_pass", int'(pass), 1);
      chk("t3_x", int'(xv), 0);

`ifdef STOP_ON_FAIL_EN
      wr(2, 9'b000_011_000);
      run(10, 1'b0, cyc);
      chk("t6_cycles", cyc, 2 + 1 + 2);
      chk("t6_pass", int'(pass), 0);
      chk("t6_err", int'(err_cnt), 1);
      chk("t6_ff", int'(first_fail), 2);
      chk("t6_x", int'(xv), 0);
      repeat (3) @(negedge clk);
      chk("t6_x_after", int'(xv), 0);
      chk("t6_done_hold", int'(done), 1);
`else
      // Writes and starts while busy are dropped
      run(10, 1'b1, cyc);
      chk("busy_ign_cycles", cyc, 12);
      chk("busy_ign_pass", int'(pass), 1);
      run(10, 1'b0, cyc);
      chk("busy_ign_tbl", int'(pass), 1);

      // Write and start together: run sees corrupted entry 4
      wr_en = 1'b1; wr_addr = 4'd4; wr_data = 9'b011_000_010;
      run(10, 1'b0, cyc);
      chk("t2_cycles", cyc, 12);
      chk("t2_pass", int'(pass), 0);
      chk("t2_err", int'(err_cnt), 1);
      chk("t2_ff", int'(first_fail), 4);

      // Reset while vector 5 is on x
      start = 1'b1; num_vec = 5'd10;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("t5_mid_x", int'(xv), 3);
      chk("t5_mid_err", int'(err_cnt), 1);
      chk("t5_mid_busy", int'(busy), 1);
      nreset = 1'b0;
      #1;
      chk("t5_rst_x", int'(xv), 0);
      chk("t5_rst_busy", int'(busy), 0);
      chk("t5_rst_done", int'(done), 0);
      chk("t5_rst_err", int'(err_cnt), 0);
      chk("t5_rst_ff", int'(first_fail), 0);
      @(negedge clk);
      nreset = 1'b1;
      @(negedge clk);
      run(10, 1'b0, cyc);
      chk("t5_tbl_kept_err", int'(err_cnt), 1);
      chk("t5_tbl_kept_ff", int'(first_fail), 4);
      wr(4, gold[4]);
      run(10, 1'b0, cyc);
      chk("t5_fresh_pass", int'(pass), 1);

      // Tied-off FSM, every expected value wrong
      tie_off = 1'b1;
      for (int i = 0; i < 16; i++) wr(i, {i[2:0], 6'b111_111});
      run(16, 1'b0, cyc);
      chk("t4_cycles", cyc, 18);
      chk("t4_err", int'(err_cnt), 16);
      chk("t4_ff", int'(first_fail), 0);
      chk("t4_pass", int'(pass), 0);
      run(31, 1'b0, cyc);
      chk("clamp_cycles", cyc, 18);
      chk("clamp_err", int'(err_cnt), 16);

      // 300 mismatches in one run on the deep instance
      for (int i = 0; i < 300; i++) begin
         b_wr_en = 1'b1; b_wr_addr = 9'(i); b_wr_data = 9'b000_111_111;
         @(negedge clk);
      end
      b_wr_en = 1'b0;
      b_start = 1'b1; b_num_vec = 10'd300;
      @(negedge clk);
      b_start = 1'b0;
      cyc = 1;
      while (!b_done && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      chk("sat_done", int'(b_done), 1);
      chk("sat_cycles", cyc, 303);
      chk("sat_err", int'(b_err), 255);
      chk("sat_ff", int'(b_ff), 0);
      chk("sat_pass", int'(b_pass), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
